// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RV32I pipeline: word loads/stores over a req/ack handshake.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [31:0]       ALUOutIn,
    input  logic [31:0]       ReadData2In,
    input  logic              RegWriteIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic              MemToRegIn,
    input  logic [4:0]        WriteRegIn,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic [4:0]        WriteRegOut,
    output logic [31:0]       ALUResultOut,
    output logic [31:0]       ReadDataOut,
    output logic              mem_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic        lat_regwrite;
    logic        lat_memtoreg;
    logic        lat_store;
    logic [4:0]  lat_wreg;
    logic [31:0] lat_alu;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    assign stall = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            WriteRegOut  <= '0;
            ALUResultOut <= '0;
            ReadDataOut  <= '0;
            mem_err      <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_memtoreg <= 1'b0;
            lat_store    <= 1'b0;
            lat_wreg     <= '0;
            lat_alu      <= '0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            wb_valid <= 1'b0;
            mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!MemReadIn && !MemWriteIn) begin
                            wb_valid     <= 1'b1;
                            RegWriteOut  <= RegWriteIn;
                            MemToRegOut  <= MemToRegIn;
                            WriteRegOut  <= WriteRegIn;
                            ALUResultOut <= ALUOutIn;
                        end else if (ALUOutIn[1:0] != 2'b00) begin
                            // Misaligned: retire immediately with the write suppressed.
                            wb_valid     <= 1'b1;
                            mem_err      <= 1'b1;
                            RegWriteOut  <= 1'b0;
                            MemToRegOut  <= MemToRegIn;
                            WriteRegOut  <= WriteRegIn;
                            ALUResultOut <= ALUOutIn;
                        end else begin
                            state        <= ACCESS;
                            dmem_req     <= 1'b1;
                            dmem_we      <= MemWriteIn;
                            dmem_addr    <= ALUOutIn[ADDR_W-1:0];
                            dmem_wdata   <= ReadData2In;
                            lat_regwrite <= RegWriteIn;
                            lat_memtoreg <= MemToRegIn;
                            lat_store    <= MemWriteIn;
                            lat_wreg     <= WriteRegIn;
                            lat_alu      <= ALUOutIn;
`ifdef MEM_TIMEOUT_EN
                            tmo_cnt      <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        RegWriteOut  <= lat_regwrite & ~lat_store;
                        MemToRegOut  <= lat_memtoreg;
                        WriteRegOut  <= lat_wreg;
                        ALUResultOut <= lat_alu;
                        if (!lat_store) ReadDataOut <= dmem_rdata;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state        <= IDLE;
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        mem_err      <= 1'b1;
                        RegWriteOut  <= 1'b0;
                        MemToRegOut  <= lat_memtoreg;
                        WriteRegOut  <= lat_wreg;
                        ALUResultOut <= lat_alu;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the Execute stage in the 5-stage RV32I pipeline.
- Consumes Execute's ALU result, store data, memory/writeback controls and destination register.
- Performs word loads/stores to the data memory over a req/ack handshake and stalls upstream while a transaction is outstanding.
- Presents registered MEM/WB results to the writeback stage.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS before abort (used only with MEM_TIMEOUT_EN).
- ADDR_W, 32: data-memory address width; low 2 bits are the byte offset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  Execute outputs carry a valid instruction.
- ALUOutIn  in  32  ALU result; memory address for loads/stores.
- ReadData2In  in  32  store data.
- RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn  in  1 each  controls from Execute.
- WriteRegIn  in  5  destination register.
- stall  out  1  hold Execute/upstream registers; combinational, equals (state != IDLE).
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_addr  out  ADDR_W  word-aligned address, registered.
- dmem_wdata  out  32  store data, registered.
- dmem_rdata  in  32  load data; sampled in the cycle dmem_ack = 1.
- dmem_ack  in  1  single-cycle completion pulse.
- wb_valid  out  1  MEM/WB registers hold a valid instruction.
- RegWriteOut, MemToRegOut  out  1 each  registered writeback controls.
- WriteRegOut  out  5  registered destination register.
- ALUResultOut  out  32  registered ALU result.
- ReadDataOut  out  32  registered load data.
- mem_err  out  1  one-cycle pulse on aborted access.

Behaviour:
- Reset (async, rst = 1): state = IDLE. All outputs and internal latches = 0, including dmem_req, wb_valid, mem_err and stall. An in-flight request is dropped. An ack arriving after reset is ignored because state is IDLE.
- IDLE: accepts Execute outputs only in this state. ex_valid = 0 gives a bubble: wb_valid = 0 next cycle, other MEM/WB registers hold.
- Non-memory op (ex_valid = 1, MemReadIn = 0, MemWriteIn = 0): 1-cycle latency. Next cycle wb_valid = 1 and RegWrite/MemToReg/WriteReg/ALUResult are registered from the inputs. ReadDataOut holds its value.
- Memory op, aligned (ALUOutIn[1:0] = 0): latch address, data and controls; next state = ACCESS. Next cycle dmem_req = 1, dmem_we = MemWriteIn, dmem_addr = ALUOutIn, dmem_wdata = ReadData2In. wb_valid = 0 meanwhile.
- Memory op, misaligned: no request is issued. Next cycle wb_valid = 1, RegWriteOut forced 0, mem_err = 1 for one cycle. State stays IDLE.
- If MemReadIn and MemWriteIn are both 1, the op is treated as a store.
- ACCESS: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until dmem_ack.
- On dmem_ack:
  - next state = IDLE and dmem_req = 0 next cycle.
  - ReadDataOut = dmem_rdata for loads; held for stores.
  - wb_valid = 1 next cycle with the latched controls. A store forces RegWriteOut = 0 regardless of input.
- The instruction presented by Execute during the ack cycle is not accepted, since stall is still 1. It is accepted in the following IDLE cycle.
- Latency: op accepted in cycle N; req visible in N+1; ack in cycle N+k (k ≥ 1); wb_valid = 1 in N+k+1. Back-to-back memory ops are therefore separated by at least 1 idle cycle.
- mem_err and wb_valid are single-cycle pulses per instruction.
- dmem_ack while in IDLE is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With macro: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES:
  - dmem_req drops and state = IDLE.
  - Next cycle wb_valid = 1, RegWriteOut = 0, mem_err = 1.
  - ack in the same cycle as the limit takes priority as normal completion.
- Without macro: no counter; ACCESS waits indefinitely. mem_err reports misalignment only.

Test Plan:
- ALU op: ex_valid = 1, ALUOutIn = 0x1234, RegWriteIn = 1, WriteRegIn = 5 -> next cycle wb_valid = 1, ALUResultOut = 0x1234, WriteRegOut = 5, stall never asserted.
- Load: addr 0x100, ack 3 cycles after req with rdata 0xDEADBEEF -> req held 3 cycles at addr 0x100, dmem_we = 0, stall = 1 throughout, then wb_valid = 1, ReadDataOut = 0xDEADBEEF, MemToRegOut = 1.
- Store: addr 0x200, data 0xCAFEF00D, RegWriteIn = 1, ack after 1 cycle -> dmem_we = 1, dmem_wdata = 0xCAFEF00D, then wb_valid = 1 with RegWriteOut = 0.
- Misaligned load at addr 0x102 -> dmem_req never rises; next cycle mem_err = 1, wb_valid = 1, RegWriteOut = 0.
- Reset mid-ACCESS: assert rst 2 cycles after req, then ack 1 cycle after rst deasserts -> dmem_req = 0 immediately, wb_valid stays 0, stall = 0, late ack ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> req drops after 4 ACCESS cycles, then mem_err = 1, wb_valid = 1, RegWriteOut = 0, stall = 0.
